// File: rtl/psram_task_ctrl.sv
// PSRAM DMA task scheduler: active-task list, trigger pending state, round-robin
// selection, req/gnt/done handshake to the DMA engine and completion IRQ status.
module psram_task_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic        dma_en,
  input  logic        task_load,
  input  logic        task_add,
  input  logic        task_remove,
  input  logic [7:0]  task_val,
  input  logic [2:0]  task_max,
  input  logic [31:0] task_trig,
  input  logic [7:0]  irq_en,
  input  logic [7:0]  irq_clr,
  input  logic [7:0]  trig_in,
  input  logic        task_gnt,
  input  logic        dma_done,
  output logic [7:0]  task_list,
  output logic [7:0]  irq_status,
  output logic        irq,
  output logic        task_req,
  output logic [2:0]  task_id,
  output logic        task_busy
);

  localparam int unsigned NUM_TASKS = 8;
  localparam int unsigned ID_W      = 3;

  typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

  state_t                 state, state_n;
  logic [NUM_TASKS-1:0]   pend, pend_n;
  logic [NUM_TASKS-1:0]   trig_q;
  logic [NUM_TASKS-1:0]   trig_edge, free_run, ready;
  logic [NUM_TASKS-1:0]   task_list_n, irq_status_n;
  logic [NUM_TASKS-1:0]   gnt_clr, done_vec, rem_mask;
  logic [ID_W-1:0]        rr, rr_n, rr_idx, pick, task_id_n;
  logic                   pick_vld, task_req_n;

  // Per-task trigger edge detect, free-run flag and readiness
  always_comb begin
    trig_edge = '0;
    free_run  = '0;
    ready     = '0;
    for (int i = 0; i < int'(NUM_TASKS); i++) begin
      free_run[i]  = task_trig[4*i+3];
      trig_edge[i] = trig_in[task_trig[4*i +: 3]] & ~trig_q[task_trig[4*i +: 3]];
      ready[i]     = task_list[i] & (ID_W'(i) <= task_max) & (pend[i] | free_run[i]);
    end
  end

  // Round-robin pick: scan downward so the smallest offset from rr wins
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    rr_idx   = '0;
    for (int k = int'(NUM_TASKS) - 1; k >= 0; k--) begin
      rr_idx = rr + ID_W'(k);
      if (ready[rr_idx]) begin
        pick     = rr_idx;
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n    = state;
    task_req_n = task_req;
    task_id_n  = task_id;
    rr_n       = rr;
    gnt_clr    = '0;
    done_vec   = '0;
    rem_mask   = task_remove ? task_val : '0;

    case (state)
      IDLE: begin
        if (dma_en && pick_vld) begin
          task_id_n  = pick;
          task_req_n = 1'b1;
          state_n    = REQ;
        end
      end
      REQ: begin
        if (task_gnt) begin
          gnt_clr[task_id] = 1'b1;
          rr_n             = task_id + ID_W'(1);
          task_req_n       = 1'b0;
          state_n          = BUSY;
        end else if (!dma_en) begin
          task_req_n = 1'b0;
          state_n    = IDLE;
        end
      end
      BUSY: begin
        if (dma_done) begin
          done_vec[task_id] = 1'b1;
          state_n           = IDLE;
        end
      end
      default: begin
        task_req_n = 1'b0;
        state_n    = IDLE;
      end
    endcase

    task_list_n  = ((task_load ? task_val : task_list) | (task_add ? task_val : '0)) & ~rem_mask;
    // An edge outranks the grant clear; removal clears regardless
    pend_n       = ((pend & ~gnt_clr) | trig_edge) & ~rem_mask;
    irq_status_n = (irq_status | done_vec) & ~irq_clr;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      task_list  <= '0;
      irq_status <= '0;
      task_req   <= 1'b0;
      task_id    <= '0;
      rr         <= '0;
      pend       <= '0;
      trig_q     <= '0;
    end else begin
      state      <= state_n;
      task_list  <= task_list_n;
      irq_status <= irq_status_n;
      task_req   <= task_req_n;
      task_id    <= task_id_n;
      rr         <= rr_n;
      pend       <= pend_n;
      trig_q     <= trig_in;
    end
  end

  assign task_busy = (state != IDLE);
  assign irq       = |(irq_status & irq_en);

endmodule
